// File: rtl/alarm_check_fsm.sv
// alarm_check_fsm: alarm trigger plus wake-up mini-game controller.
// Watches current_time against alarm_time on each seconds tick, rings on a
// match, then requires ROUNDS consecutive correct switch patterns (each
// confirmed with a press of the middle button) before raising finish4.
// Optional build macro: GAME_TIMEOUT_EN -- when defined, GAME_TIMEOUT_S
// seconds without a press in GAME drops the game back to RINGING.
module alarm_check_fsm #(
    parameter int ROUNDS         = 3,
    parameter int GAME_TIMEOUT_S = 20
) (
    input  logic        clk_osc,
    input  logic        resetn,
    input  logic        enable,
    input  logic        tick,
    input  logic [15:0] current_time,
    input  logic [15:0] alarm_time,
    input  logic        push_m,
    input  logic [9:0]  mini_game_sw,
    output logic [9:0]  mini_game_led,
    output logic [2:0]  alarm_state,
    output logic        ring_blink,
    output logic        finish4
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_RINGING = 3'd2,
        S_GAME    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    // Elaboration-time guard on the parameter ranges the counters are sized for.
    if (ROUNDS < 1 || ROUNDS > 7 || GAME_TIMEOUT_S < 1) begin : g_param_check
        $error("alarm_check_fsm: ROUNDS must be 1..7 and GAME_TIMEOUT_S >= 1");
    end

    localparam logic [2:0] LAST_ROUND = 3'(ROUNDS - 1);

    state_t      state_reg, state_next;
    logic [2:0]  round_reg, round_next;
    logic [9:0]  pattern_reg, pattern_next;
    logic [9:0]  led_reg, led_next;
    logic        blink_reg, blink_next;
    logic        finish_reg, finish_next;
    logic [2:0]  alarm_state_reg, alarm_state_next;
    logic [9:0]  lfsr_reg;
    logic        push_meta_reg, push_sync_reg, push_prev_reg;
    logic        press;
    logic [3:0]  digit_ok;
    logic        alarm_valid;
    logic        time_match;

`ifdef GAME_TIMEOUT_EN
    localparam int TW = (GAME_TIMEOUT_S < 2) ? 1 : $clog2(GAME_TIMEOUT_S + 1);
    localparam logic [TW-1:0] SECS_LAST = TW'(GAME_TIMEOUT_S - 1);
    logic [TW-1:0] secs_reg, secs_next;
`endif

    // Bring the asynchronous button into clk_osc and keep one stage of history for edge detection.
    always_ff @(posedge clk_osc) begin
        if (!resetn) begin
            push_meta_reg <= 1'b0;
            push_sync_reg <= 1'b0;
            push_prev_reg <= 1'b0;
        end else begin
            push_meta_reg <= push_m;
            push_sync_reg <= push_meta_reg;
            push_prev_reg <= push_sync_reg;
        end
    end

    // A held button produces exactly one press on its synchronized rising edge.
    assign press = push_sync_reg & ~push_prev_reg;

    // Free-running pattern source: x^10 + x^7 + 1 is primitive, so a nonzero seed never reaches zero.
    always_ff @(posedge clk_osc) begin
        if (!resetn) begin
            lfsr_reg <= 10'h2A5;
        end else begin
            lfsr_reg <= {lfsr_reg[8:0], lfsr_reg[9] ^ lfsr_reg[6]};
        end
    end

    // Per-digit BCD range check of alarm_time; tens digits (S1, M1) stop at 5.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            localparam logic [3:0] LIMIT = (gi == 1 || gi == 3) ? 4'd5 : 4'd9;
            assign digit_ok[gi] = (alarm_time[gi*4 +: 4] <= LIMIT);
        end
    endgenerate

    assign alarm_valid = &digit_ok;
    assign time_match  = (current_time == alarm_time);

    // State register and all registered outputs.
    always_ff @(posedge clk_osc) begin
        if (!resetn) begin
            state_reg       <= S_IDLE;
            round_reg       <= 3'd0;
            pattern_reg     <= 10'd0;
            led_reg         <= 10'd0;
            blink_reg       <= 1'b0;
            finish_reg      <= 1'b0;
            alarm_state_reg <= 3'b000;
`ifdef GAME_TIMEOUT_EN
            secs_reg        <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            round_reg       <= round_next;
            pattern_reg     <= pattern_next;
            led_reg         <= led_next;
            blink_reg       <= blink_next;
            finish_reg      <= finish_next;
            alarm_state_reg <= alarm_state_next;
`ifdef GAME_TIMEOUT_EN
            secs_reg        <= secs_next;
`endif
        end
    end

    // Next-state and next-output decode; enable low overrides everything else.
    always_comb begin
        state_next   = state_reg;
        round_next   = round_reg;
        pattern_next = pattern_reg;
        led_next     = led_reg;
        blink_next   = blink_reg;
        finish_next  = 1'b0;
`ifdef GAME_TIMEOUT_EN
        secs_next    = secs_reg;
`endif
        if (!enable) begin
            state_next = S_IDLE;
            round_next = 3'd0;
            led_next   = 10'd0;
            blink_next = 1'b0;
`ifdef GAME_TIMEOUT_EN
            secs_next  = '0;
`endif
        end else begin
            case (state_reg)
                S_IDLE: begin
                    state_next = S_ARMED;
                end
                S_ARMED: begin
                    // Only a tick cycle carries a fresh time; an invalid alarm can never match.
                    if (tick && time_match && alarm_valid) begin
                        state_next = S_RINGING;
                    end
                end
                S_RINGING: begin
                    if (tick) begin
                        blink_next = ~blink_reg;
                    end
                    if (press) begin
                        state_next   = S_GAME;
                        round_next   = 3'd0;
                        pattern_next = lfsr_reg;
                        led_next     = lfsr_reg;
`ifdef GAME_TIMEOUT_EN
                        secs_next    = '0;
`endif
                    end
                end
                S_GAME: begin
                    if (tick) begin
                        blink_next = ~blink_reg;
                    end
                    if (press) begin
                        // Every press draws a fresh pattern, right or wrong.
                        pattern_next = lfsr_reg;
                        led_next     = lfsr_reg;
`ifdef GAME_TIMEOUT_EN
                        secs_next    = '0;
`endif
                        if (mini_game_sw == pattern_reg) begin
                            if (round_reg == LAST_ROUND) begin
                                state_next  = S_DONE;
                                finish_next = 1'b1;
                                blink_next  = 1'b0;
                                led_next    = 10'd0;
                                round_next  = 3'd0;
                            end else begin
                                round_next = round_reg + 3'd1;
                            end
                        end else begin
                            round_next = 3'd0;
                        end
                    end
`ifdef GAME_TIMEOUT_EN
                    else if (tick) begin
                        if (secs_reg == SECS_LAST) begin
                            state_next = S_RINGING;
                            round_next = 3'd0;
                            led_next   = 10'd0;
                            secs_next  = '0;
                        end else begin
                            secs_next = secs_reg + TW'(1);
                        end
                    end
`endif
                end
                S_DONE: begin
                    blink_next = 1'b0;
                    led_next   = 10'd0;
                end
                default: begin
                    state_next = S_IDLE;
                    round_next = 3'd0;
                    led_next   = 10'd0;
                    blink_next = 1'b0;
                end
            endcase
        end

        case (state_next)
            S_RINGING: alarm_state_next = 3'b001;
            S_GAME:    alarm_state_next = 3'b010;
            S_DONE:    alarm_state_next = 3'b100;
            default:   alarm_state_next = 3'b000;
        endcase
    end

    assign mini_game_led = led_reg;
    assign alarm_state   = alarm_state_reg;
    assign ring_blink    = blink_reg;
    assign finish4       = finish_reg;

endmodule

// File: tb/tb_alarm_check_fsm.sv
// tb_alarm_check_fsm: scoreboard bench for alarm_check_fsm. A behavioural
// model steps once per clock edge with the applied inputs and queues the
// expected outputs; a monitor on the falling edge pops and compares.
module tb_alarm_check_fsm;

    localparam int ROUNDS = 3;
    localparam int TO_S   = 20;

    localparam int M_IDLE = 0;
    localparam int M_ARMED = 1;
    localparam int M_RING = 2;
    localparam int M_GAME = 3;
    localparam int M_DONE = 4;

    logic        clk_osc = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] current_time = 16'h0000;
    logic [15:0] alarm_time = 16'h0000;
    logic        push_m = 1'b0;
    logic [9:0]  mini_game_sw = 10'd0;
    logic [9:0]  mini_game_led;
    logic [2:0]  alarm_state;
    logic        ring_blink;
    logic        finish4;

    always #5 clk_osc = ~clk_osc;

    alarm_check_fsm #(
        .ROUNDS(ROUNDS),
        .GAME_TIMEOUT_S(TO_S)
    ) dut (
        .clk_osc(clk_osc),
        .resetn(resetn),
        .enable(enable),
        .tick(tick),
        .current_time(current_time),
        .alarm_time(alarm_time),
        .push_m(push_m),
        .mini_game_sw(mini_game_sw),
        .mini_game_led(mini_game_led),
        .alarm_state(alarm_state),
        .ring_blink(ring_blink),
        .finish4(finish4)
    );

    typedef struct packed {
        logic [9:0] led;
        logic [2:0] st;
        logic       blink;
        logic       fin;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model state
    int         m_mode = M_IDLE;
    int         m_rounds = 0;
    int         m_secs = 0;
    logic [9:0] m_pat = 10'd0;
    logic [9:0] m_led = 10'd0;
    logic [9:0] m_lfsr = 10'h2A5;
    logic       m_blink = 1'b0;
    logic       m_fin = 1'b0;
    bit         h0 = 0, h1 = 0, h2 = 0;   // push_m sampled 1, 2, 3 edges ago

    function automatic bit bcd_ok(input logic [15:0] t);
        int m1, m0, s1, s0;
        m1 = int'(t[15:12]);
        m0 = int'(t[11:8]);
        s1 = int'(t[7:4]);
        s0 = int'(t[3:0]);
        return (m1 <= 5) && (m0 <= 9) && (s1 <= 5) && (s0 <= 9);
    endfunction

    function automatic logic [9:0] lfsr_step(input logic [9:0] v);
        logic fb;
        fb = v[9] ^ v[6];
        return ((v << 1) & 10'h3FF) | {9'd0, fb};
    endfunction

    // One clock edge of the specified behaviour, using the inputs applied in the cycle before it.
    task automatic model_step();
        exp_t e;
        bit   press;
        logic [9:0] cur_lfsr;
        if (!resetn) begin
            m_mode = M_IDLE; m_rounds = 0; m_secs = 0;
            m_pat = 10'd0; m_led = 10'd0; m_lfsr = 10'h2A5;
            m_blink = 1'b0; m_fin = 1'b0;
            h0 = 0; h1 = 0; h2 = 0;
        end else begin
            press = h1 && !h2;          // button high two edges ago, low three edges ago
            h2 = h1; h1 = h0; h0 = push_m;
            cur_lfsr = m_lfsr;
            m_lfsr = lfsr_step(m_lfsr);
            m_fin = 1'b0;
            if (!enable) begin
                m_mode = M_IDLE; m_rounds = 0; m_led = 10'd0; m_blink = 1'b0; m_secs = 0;
            end else begin
                case (m_mode)
                    M_IDLE: m_mode = M_ARMED;
                    M_ARMED: if (tick && current_time == alarm_time && bcd_ok(alarm_time)) m_mode = M_RING;
                    M_RING: begin
                        if (tick) m_blink = !m_blink;
                        if (press) begin
                            m_mode = M_GAME; m_rounds = 0; m_pat = cur_lfsr; m_led = cur_lfsr; m_secs = 0;
                        end
                    end
                    M_GAME: begin
                        if (tick) m_blink = !m_blink;
                        if (press) begin
                            m_secs = 0;
                            if (mini_game_sw == m_pat) begin
                                if (m_rounds + 1 == ROUNDS) begin
                                    m_mode = M_DONE; m_fin = 1'b1; m_blink = 1'b0; m_led = 10'd0; m_rounds = 0;
                                end else begin
                                    m_rounds = m_rounds + 1; m_pat = cur_lfsr; m_led = cur_lfsr;
                                end
                            end else begin
                                m_rounds = 0; m_pat = cur_lfsr; m_led = cur_lfsr;
                            end
                        end
`ifdef GAME_TIMEOUT_EN
                        else if (tick) begin
                            m_secs = m_secs + 1;
                            if (m_secs == TO_S) begin
                                m_mode = M_RING; m_rounds = 0; m_led = 10'd0; m_secs = 0;
                            end
                        end
`endif
                    end
                    default: begin m_blink = 1'b0; m_led = 10'd0; end
                endcase
            end
        end
        e.led   = m_led;
        e.blink = m_blink;
        e.fin   = m_fin;
        e.st    = (m_mode == M_RING) ? 3'b001 : (m_mode == M_GAME) ? 3'b010 :
                  (m_mode == M_DONE) ? 3'b100 : 3'b000;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are registered, so they are stable by the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_osc);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (alarm_state !== e.st) begin
                    n_bad++;
                    $display("FAIL alarm_state t=%0t got %b want %b", $time, alarm_state, e.st);
                end
                if (mini_game_led !== e.led) begin
                    n_bad++;
                    $display("FAIL mini_game_led t=%0t got %h want %h", $time, mini_game_led, e.led);
                end
                if (ring_blink !== e.blink) begin
                    n_bad++;
                    $display("FAIL ring_blink t=%0t got %b want %b", $time, ring_blink, e.blink);
                end
                if (finish4 !== e.fin) begin
                    n_bad++;
                    $display("FAIL finish4 t=%0t got %b want %b", $time, finish4, e.fin);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk_osc);
        model_step();
        @(negedge clk_osc);
    endtask

    task automatic press_with(input logic [9:0] s, input string what);
        mini_game_sw = s;
        push_m = 1'b1;
        repeat (3) cyc();
        push_m = 1'b0;
        repeat (3) cyc();
        $display("press %-8s sw=%h -> mode=%0d rounds=%0d", what, s, m_mode, m_rounds);
    endtask

    task automatic ring_at(input logic [15:0] t);
        alarm_time = t;
        enable = 1'b1;
        repeat (2) cyc();
        current_time = t;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        $display("ring alarm=%h -> mode=%0d", t, m_mode);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
        end
    endtask

    logic [15:0] sweep_a [4] = '{16'h0103, 16'h0104, 16'h0105, 16'h0105};
    logic [15:0] sweep_b [4] = '{16'h0168, 16'h0169, 16'h0170, 16'h0171};

    initial begin
        resetn = 1'b0;
        repeat (3) cyc();
        resetn = 1'b1;
        cyc();

        // Match at 01:05 only, not at 01:04
        alarm_time = 16'h0105;
        enable = 1'b1;
        repeat (2) cyc();
        for (int i = 0; i < 3; i++) begin
            current_time = sweep_a[i];
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
            $display("tick time=%h -> mode=%0d", sweep_a[i], m_mode);
        end
        press_with(10'h000, "start");
        for (int i = 0; i < ROUNDS; i++) press_with(m_pat, "correct");
        repeat (3) cyc();
        enable = 1'b0;
        cyc();

        // Invalid alarm never triggers
        alarm_time = 16'h0170;
        enable = 1'b1;
        repeat (2) cyc();
        for (int i = 0; i < 4; i++) begin
            current_time = sweep_b[i];
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            cyc();
            $display("tick time=%h alarm=%h -> mode=%0d", sweep_b[i], alarm_time, m_mode);
        end
        enable = 1'b0;
        cyc();

        // Two correct, one wrong, then a full run is needed
        ring_at(16'h0230);
        press_with(10'h000, "start");
        press_with(m_pat, "correct");
        press_with(m_pat, "correct");
        press_with(m_pat ^ 10'h001, "wrong");
        for (int i = 0; i < ROUNDS; i++) press_with(m_pat, "correct");
        enable = 1'b0;
        cyc();

        // enable drop coincides with the winning press
        ring_at(16'h5959);
        press_with(10'h000, "start");
        press_with(m_pat, "correct");
        press_with(m_pat, "correct");
        mini_game_sw = m_pat;
        push_m = 1'b1;
        cyc();
        cyc();
        enable = 1'b0;
        cyc();
        push_m = 1'b0;
        repeat (3) cyc();
        $display("press with enable drop -> mode=%0d", m_mode);

`ifdef GAME_TIMEOUT_EN
        ring_at(16'h0001);
        press_with(10'h000, "start");
        ticks(TO_S - 1);
        press_with(m_pat, "correct");
        ticks(TO_S - 1);
        ticks(1);
        $display("timeout -> mode=%0d", m_mode);
        enable = 1'b0;
        cyc();
`endif

        // Randomized traffic
        alarm_time = {4'($urandom % 6), 4'($urandom % 10), 4'($urandom % 6), 4'($urandom % 10)};
        for (int i = 0; i < 4000; i++) begin
            resetn = ($urandom % 700) != 0;
            enable = ($urandom % 200) != 0;
            if (m_mode == M_DONE && ($urandom % 6) == 0) enable = 1'b0;
            if (($urandom % 400) == 0) begin
                if ($urandom % 3 == 0) alarm_time = 16'($urandom);
                else alarm_time = {4'($urandom % 6), 4'($urandom % 10), 4'($urandom % 6), 4'($urandom % 10)};
            end
            tick = ($urandom % 4) == 0;
            if (tick) current_time = (($urandom % 3) == 0) ? alarm_time : 16'($urandom);
            if (($urandom % 5) == 0) push_m = ~push_m;
            mini_game_sw = (($urandom % 4) != 0) ? m_pat : 10'($urandom);
            cyc();
            if (m_fin) $display("random cycle %0d: finish reached", i);
        end
        resetn = 1'b1;
        tick = 1'b0;
        push_m = 1'b0;
        cyc();

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk_osc);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain queue left=%0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
